// File: rtl/dlm_pkg.sv
// Shared types and helpers for the dataflow deadlock monitor: FSM state encoding,
// wait-for graph masking and lowest-index selection.
package dlm_pkg;

  localparam int MAX_PROC = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SEARCH,
    EVAL,
    HOLD,
    REPORT
  } dlm_state_e;

  // One edge of the effective graph: only blocked processes wait, and self-waits never count.
  function automatic logic mask_graph(input logic dep_bit, input logic blk_bit,
                                      input int i, input int j);
    return dep_bit & blk_bit & (i != j);
  endfunction

  function automatic int lowest_set_idx(input logic [MAX_PROC-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_PROC - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/dlm_reach_step.sv
// One hop of reachability closure: a row gains every successor of every node it already reaches.
module dlm_reach_step #(
  parameter int N_PROC = 4
) (
  input  logic [N_PROC*N_PROC-1:0] r_in,
  input  logic [N_PROC*N_PROC-1:0] d_in,
  output logic [N_PROC*N_PROC-1:0] r_out
);

  // NOTE: assigning r_out before the loop gives every path a value, so no latch is inferred.
  always_comb begin
    r_out = r_in;
    for (int i = 0; i < N_PROC; i++) begin
      for (int j = 0; j < N_PROC; j++) begin
        if (r_in[i*N_PROC+j]) begin
          r_out[i*N_PROC +: N_PROC] = r_out[i*N_PROC +: N_PROC] | d_in[j*N_PROC +: N_PROC];
        end
      end
    end
  end

endmodule

// File: rtl/dataflow_deadlock_monitor.sv
// Watches blocked flags and the wait-for matrix, waits for a stable pattern, then searches for cycles.
// Optional DLM_SNAPSHOT_EN adds snap_mat, the wait-for matrix captured at detection.
module dataflow_deadlock_monitor
  import dlm_pkg::*;
#(
  parameter  int N_PROC        = 4,
  parameter  int STABLE_CYCLES = 16,
  localparam int IDX_W         = $clog2(N_PROC),
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1),
  localparam int MAT_W         = N_PROC * N_PROC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_PROC-1:0] proc_blk,
  input  logic [MAT_W-1:0]  dep_mat,
  input  logic              dl_clear,
  output logic              busy,
  output logic              dl_detect,
  output logic [N_PROC-1:0] dl_cycle_vec,
  output logic [IDX_W-1:0]  dl_origin
`ifdef DLM_SNAPSHOT_EN
  ,
  output logic [MAT_W-1:0]  snap_mat
`endif
);

  dlm_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  step_q, step_d;
  logic [N_PROC-1:0] lat_blk_q, lat_blk_d;
  logic [MAT_W-1:0]  lat_dep_q, lat_dep_d;
  logic [MAT_W-1:0]  reach_q, reach_d;
  logic              dl_detect_q, dl_detect_d;
  logic [N_PROC-1:0] dl_cycle_vec_q, dl_cycle_vec_d;
  logic [IDX_W-1:0]  dl_origin_q, dl_origin_d;
`ifdef DLM_SNAPSHOT_EN
  logic [MAT_W-1:0]  snap_q, snap_d;
`endif

  logic [MAT_W-1:0]    graph;
  logic [MAT_W-1:0]    reach_next;
  logic [N_PROC-1:0]   cyc;
  logic [MAX_PROC-1:0] cyc_wide;
  logic                inputs_same;

  assign inputs_same = (proc_blk == lat_blk_q) && (dep_mat == lat_dep_q);

  always_comb begin
    graph    = '0;
    cyc      = '0;
    cyc_wide = '0;
    for (int i = 0; i < N_PROC; i++) begin
      for (int j = 0; j < N_PROC; j++) begin
        graph[i*N_PROC+j] = mask_graph(lat_dep_q[i*N_PROC+j], lat_blk_q[i], i, j);
      end
      cyc[i] = reach_q[i*N_PROC+i];
    end
    cyc_wide[N_PROC-1:0] = cyc;
  end

  dlm_reach_step #(.N_PROC(N_PROC)) u_reach_step (
    .r_in  (reach_q),
    .d_in  (graph),
    .r_out (reach_next)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    step_d         = step_q;
    lat_blk_d      = lat_blk_q;
    lat_dep_d      = lat_dep_q;
    reach_d        = reach_q;
    dl_detect_d    = dl_detect_q;
    dl_cycle_vec_d = dl_cycle_vec_q;
    dl_origin_d    = dl_origin_q;
`ifdef DLM_SNAPSHOT_EN
    snap_d         = snap_q;
`endif
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|proc_blk) begin
            lat_blk_d = proc_blk;
            lat_dep_d = dep_mat;
            cnt_d     = CNT_W'(1);
            state_d   = SETTLE;
          end
        end
        SETTLE: begin
          // A changed pattern takes priority over a terminal count: restart on the new pattern.
          if (proc_blk == '0) begin
            state_d = IDLE;
          end else if (!inputs_same) begin
            lat_blk_d = proc_blk;
            lat_dep_d = dep_mat;
            cnt_d     = CNT_W'(1);
          end else if (cnt_q == CNT_W'(STABLE_CYCLES)) begin
            reach_d = graph;
            step_d  = '0;
            state_d = SEARCH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SEARCH: begin
          if (!inputs_same) begin
            state_d = IDLE;
          end else begin
            reach_d = reach_next;
            if (step_q == IDX_W'(N_PROC - 2)) state_d = EVAL;
            else                              step_d  = step_q + IDX_W'(1);
          end
        end
        EVAL: begin
          if (|cyc) begin
            dl_detect_d    = 1'b1;
            dl_cycle_vec_d = cyc;
            dl_origin_d    = IDX_W'(lowest_set_idx(cyc_wide));
`ifdef DLM_SNAPSHOT_EN
            snap_d         = lat_dep_q;
`endif
            state_d        = REPORT;
          end else begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (!inputs_same) state_d = IDLE;
        end
        REPORT: begin
          if (dl_clear) begin
            dl_detect_d    = 1'b0;
            dl_cycle_vec_d = '0;
            dl_origin_d    = '0;
`ifdef DLM_SNAPSHOT_EN
            snap_d         = '0;
`endif
            state_d        = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the reach matrix is a handful of flops, not a RAM, so it is reset with everything else.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      step_q         <= '0;
      lat_blk_q      <= '0;
      lat_dep_q      <= '0;
      reach_q        <= '0;
      dl_detect_q    <= 1'b0;
      dl_cycle_vec_q <= '0;
      dl_origin_q    <= '0;
`ifdef DLM_SNAPSHOT_EN
      snap_q         <= '0;
`endif
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      step_q         <= step_d;
      lat_blk_q      <= lat_blk_d;
      lat_dep_q      <= lat_dep_d;
      reach_q        <= reach_d;
      dl_detect_q    <= dl_detect_d;
      dl_cycle_vec_q <= dl_cycle_vec_d;
      dl_origin_q    <= dl_origin_d;
`ifdef DLM_SNAPSHOT_EN
      snap_q         <= snap_d;
`endif
    end
  end

  assign busy         = (state_q == SETTLE) || (state_q == SEARCH) || (state_q == EVAL);
  assign dl_detect    = dl_detect_q;
  assign dl_cycle_vec = dl_cycle_vec_q;
  assign dl_origin    = dl_origin_q;
`ifdef DLM_SNAPSHOT_EN
  assign snap_mat     = snap_q;
`endif

endmodule

// File: tb/tb_dataflow_deadlock_monitor.sv
// Bench for dataflow_deadlock_monitor (N_PROC=4, STABLE_CYCLES=16): directed cases with literal
// expectations, then random episodes, all compared every cycle against an episode-level model.
module tb_dataflow_deadlock_monitor;

  localparam int N = 4;
  localparam int S = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        dl_clear = 1'b0;
  logic [3:0]  proc_blk = '0;
  logic [15:0] dep_mat = '0;
  logic        busy;
  logic        dl_detect;
  logic [3:0]  dl_cycle_vec;
  logic [1:0]  dl_origin;
`ifdef DLM_SNAPSHOT_EN
  logic [15:0] snap_mat;
`endif

  dataflow_deadlock_monitor #(.N_PROC(N), .STABLE_CYCLES(S)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .proc_blk     (proc_blk),
    .dep_mat      (dep_mat),
    .dl_clear     (dl_clear),
    .busy         (busy),
    .dl_detect    (dl_detect),
    .dl_cycle_vec (dl_cycle_vec),
    .dl_origin    (dl_origin)
`ifdef DLM_SNAPSHOT_EN
    ,
    .snap_mat     (snap_mat)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Episode model: WAIT (nothing tracked), TRACK (pattern held for 'age' edges),
  // HOLD (pattern searched, acyclic), REPORT (deadlock reported, waiting for clear).
  localparam int M_WAIT = 0, M_TRACK = 1, M_HOLD = 2, M_REPORT = 3;

  typedef struct {
    int          mode;
    int          age;
    logic [3:0]  pblk;
    logic [15:0] pdep;
    logic        det;
    logic [3:0]  vec;
    logic [1:0]  org;
    logic [15:0] snap;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.mode = M_WAIT; r.age = 0; r.pblk = '0; r.pdep = '0;
    r.det = 1'b0; r.vec = '0; r.org = '0; r.snap = '0;
    return r;
  endfunction

  // Transitive closure (Warshall) over the blocked, non-self wait-for edges; a node reaching itself is on a cycle.
  function automatic logic [3:0] find_cycles(input logic [3:0] blk, input logic [15:0] dep);
    bit g[4][4];
    logic [3:0] res;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        g[i][j] = dep[i*4+j] && blk[i] && (i != j);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (g[i][k] && g[k][j]) g[i][j] = 1'b1;
    for (int i = 0; i < 4; i++) res[i] = g[i][i];
    return res;
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic model_t model_step(input model_t s, input logic en, input logic [3:0] blk,
                                        input logic [15:0] dep, input logic clr);
    model_t n;
    logic same;
    logic [3:0] cyc;
    n = s;
    same = (blk == s.pblk) && (dep == s.pdep);
    if (!en) begin
      n.mode = M_WAIT;
      return n;
    end
    case (s.mode)
      M_WAIT: if (|blk) begin
        n.mode = M_TRACK; n.age = 1; n.pblk = blk; n.pdep = dep;
      end
      M_TRACK: begin
        if (s.age < S + N) begin
          if (s.age <= S && blk == '0) n.mode = M_WAIT;
          else if (!same) begin
            if (s.age <= S) begin n.age = 1; n.pblk = blk; n.pdep = dep; end
            else n.mode = M_WAIT;
          end else n.age = s.age + 1;
        end else begin
          cyc = find_cycles(s.pblk, s.pdep);
          if (|cyc) begin
            n.mode = M_REPORT; n.det = 1'b1; n.vec = cyc; n.org = lowest(cyc); n.snap = s.pdep;
          end else n.mode = M_HOLD;
        end
      end
      M_HOLD: if (!same) n.mode = M_WAIT;
      M_REPORT: if (clr) begin
        n.mode = M_WAIT; n.det = 1'b0; n.vec = '0; n.org = '0; n.snap = '0;
      end
      default: n.mode = M_WAIT;
    endcase
    return n;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) m <= model_reset();
    else        m <= model_step(m, enable, proc_blk, dep_mat, dl_clear);
  end

  always @(negedge clock) begin
    check("model_busy",   {31'd0, busy},        {31'd0, m.mode == M_TRACK});
    check("model_detect", {31'd0, dl_detect},   {31'd0, m.det});
    check("model_vec",    {28'd0, dl_cycle_vec}, {28'd0, m.vec});
    check("model_origin", {30'd0, dl_origin},   {30'd0, m.org});
`ifdef DLM_SNAPSHOT_EN
    check("model_snap",   {16'd0, snap_mat},    {16'd0, m.snap});
`endif
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] blk, input logic [15:0] dep);
    proc_blk = blk;
    dep_mat  = dep;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(2);
    check("rst_busy",   {31'd0, busy},         32'd0);
    check("rst_detect", {31'd0, dl_detect},    32'd0);
    check("rst_vec",    {28'd0, dl_cycle_vec}, 32'd0);
    check("rst_origin", {30'd0, dl_origin},    32'd0);
    reset  = 1'b1;
    enable = 1'b1;
    tick(1);

    // Two-process cycle 0<->1: detect after edge 21
    drive(4'b0011, 16'h0012);
    tick(1);
    check("c1_busy_e1", {31'd0, busy}, 32'd1);
    tick(19);
    check("c1_det_e20", {31'd0, dl_detect}, 32'd0);
    tick(1);
    check("c1_det_e21", {31'd0, dl_detect},    32'd1);
    check("c1_vec",     {28'd0, dl_cycle_vec}, 32'h3);
    check("c1_origin",  {30'd0, dl_origin},    32'd0);

    // Clear in REPORT, then clear held in SETTLE is ignored
    dl_clear = 1'b1;
    tick(1);
    check("clr_det",  {31'd0, dl_detect},    32'd0);
    check("clr_vec",  {28'd0, dl_cycle_vec}, 32'd0);
    check("clr_busy", {31'd0, busy},         32'd0);
    dl_clear = 1'b0;
    tick(1);
    dl_clear = 1'b1;
    tick(9);
    dl_clear = 1'b0;
    tick(10);
    check("settle_clr_det_e20", {31'd0, dl_detect}, 32'd0);
    tick(1);
    check("settle_clr_det_e21", {31'd0, dl_detect}, 32'd1);

    // Report survives enable drop; async reset mid-SEARCH clears it at once
    enable = 1'b0;
    tick(1);
    check("en0_det_held", {31'd0, dl_detect}, 32'd1);
    check("en0_busy",     {31'd0, busy},      32'd0);
    enable = 1'b1;
    tick(18);
    check("search_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("arst_det",  {31'd0, dl_detect},    32'd0);
    check("arst_vec",  {28'd0, dl_cycle_vec}, 32'd0);
    check("arst_busy", {31'd0, busy},         32'd0);
    tick(1);
    reset = 1'b1;
    drive('0, '0);
    tick(2);

    // Mid-SETTLE glitch restarts the count
    drive(4'b0011, 16'h0012);
    tick(10);
    drive(4'b0001, 16'h0012);
    tick(1);
    drive(4'b0011, 16'h0012);
    tick(20);
    check("glitch_det_early", {31'd0, dl_detect}, 32'd0);
    tick(1);
    check("glitch_det", {31'd0, dl_detect}, 32'd1);
    dl_clear = 1'b1;
    tick(1);
    dl_clear = 1'b0;
    drive('0, '0);
    tick(2);

    // Chain 0->1->2: HOLD, no detect, no re-search
    drive(4'b0111, 16'h0042);
    tick(21);
    check("chain_det",  {31'd0, dl_detect}, 32'd0);
    check("chain_busy", {31'd0, busy},      32'd0);
    tick(40);
    check("chain_hold_busy", {31'd0, busy},      32'd0);
    check("chain_hold_det",  {31'd0, dl_detect}, 32'd0);
    drive('0, '0);
    tick(2);

    // Three-cycle 1->2->3->1 with tail 0->1
    drive(4'b1111, 16'h2842);
    tick(21);
    check("c4_det",    {31'd0, dl_detect},    32'd1);
    check("c4_vec",    {28'd0, dl_cycle_vec}, 32'hE);
    check("c4_origin", {30'd0, dl_origin},    32'd1);
`ifdef DLM_SNAPSHOT_EN
    check("c4_snap", {16'd0, snap_mat}, 32'h2842);
`endif
    dl_clear = 1'b1;
    tick(1);
    dl_clear = 1'b0;
`ifdef DLM_SNAPSHOT_EN
    check("c4_snap_clr", {16'd0, snap_mat}, 32'd0);
`endif
    drive('0, '0);
    tick(2);

    // Self-edges only
    drive(4'b1111, 16'h8421);
    tick(25);
    check("self_det",  {31'd0, dl_detect}, 32'd0);
    check("self_busy", {31'd0, busy},      32'd0);
    drive('0, '0);
    tick(2);

    // Random episodes; the per-cycle compare process does the checking
    for (int e = 0; e < 200; e++) begin
      int len;
      drive(4'($urandom), 16'($urandom) & 16'($urandom));
      enable = ($urandom_range(0, 15) != 0);
      len = $urandom_range(1, 30);
      for (int c = 0; c < len; c++) begin
        dl_clear = ($urandom_range(0, 7) == 0);
        tick(1);
      end
    end
    dl_clear = 1'b0;
    enable   = 1'b1;
    drive('0, '0);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
